romblk_64x9: RTL and testbench

- Synchronous 64-word x 9-bit read-only memory with a registered data output.
- Holds a fixed constant table for lookup use in datapaths.
- The address is sampled through the output register on the read clock, gated by a clock enable.
- Clears asynchronously on an active-low reset.
- Needs no device-global set/reset or power-up-reset primitives. Those may be present in the system tied inactive, and they have no effect on this block.

---
 rtl/romblk_64x9.sv | 117 +++++++++++
 tb/tb_romblk_64x9.sv | 131 +++++++++++++
 2 files changed

// File: rtl/romblk_64x9.sv
// ============================================================================
// Module      : romblk_64x9
// Description : 64 x 9 synchronous ROM with enabled output register.
//               Each word holds (9*a + 5) mod 512.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module romblk_64x9 #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 9
) (
    input  logic                  OutClock,
    input  logic                  Reset,
    input  logic                  OutClockEn,
    input  logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] Q
);

    localparam logic [DATA_WIDTH-1:0] C_Q_RESET = '0;

    logic [DATA_WIDTH-1:0] rom_word;
    logic [DATA_WIDTH-1:0] q_d;
    logic [DATA_WIDTH-1:0] q_q;

    // Table entries step by 9 and wrap past 0x1FF between addresses 56 and 57.
    always_comb begin
        rom_word = C_Q_RESET;
        case (Address)
            6'd0:  rom_word = 9'h005;
            6'd1:  rom_word = 9'h00E;
            6'd2:  rom_word = 9'h017;
            6'd3:  rom_word = 9'h020;
            6'd4:  rom_word = 9'h029;
            6'd5:  rom_word = 9'h032;
            6'd6:  rom_word = 9'h03B;
            6'd7:  rom_word = 9'h044;
            6'd8:  rom_word = 9'h04D;
            6'd9:  rom_word = 9'h056;
            6'd10: rom_word = 9'h05F;
            6'd11: rom_word = 9'h068;
            6'd12: rom_word = 9'h071;
            6'd13: rom_word = 9'h07A;
            6'd14: rom_word = 9'h083;
            6'd15: rom_word = 9'h08C;
            6'd16: rom_word = 9'h095;
            6'd17: rom_word = 9'h09E;
            6'd18: rom_word = 9'h0A7;
            6'd19: rom_word = 9'h0B0;
            6'd20: rom_word = 9'h0B9;
            6'd21: rom_word = 9'h0C2;
            6'd22: rom_word = 9'h0CB;
            6'd23: rom_word = 9'h0D4;
            6'd24: rom_word = 9'h0DD;
            6'd25: rom_word = 9'h0E6;
            6'd26: rom_word = 9'h0EF;
            6'd27: rom_word = 9'h0F8;
            6'd28: rom_word = 9'h101;
            6'd29: rom_word = 9'h10A;
            6'd30: rom_word = 9'h113;
            6'd31: rom_word = 9'h11C;
            6'd32: rom_word = 9'h125;
            6'd33: rom_word = 9'h12E;
            6'd34: rom_word = 9'h137;
            6'd35: rom_word = 9'h140;
            6'd36: rom_word = 9'h149;
            6'd37: rom_word = 9'h152;
            6'd38: rom_word = 9'h15B;
            6'd39: rom_word = 9'h164;
            6'd40: rom_word = 9'h16D;
            6'd41: rom_word = 9'h176;
            6'd42: rom_word = 9'h17F;
            6'd43: rom_word = 9'h188;
            6'd44: rom_word = 9'h191;
            6'd45: rom_word = 9'h19A;
            6'd46: rom_word = 9'h1A3;
            6'd47: rom_word = 9'h1AC;
            6'd48: rom_word = 9'h1B5;
            6'd49: rom_word = 9'h1BE;
            6'd50: rom_word = 9'h1C7;
            6'd51: rom_word = 9'h1D0;
            6'd52: rom_word = 9'h1D9;
            6'd53: rom_word = 9'h1E2;
            6'd54: rom_word = 9'h1EB;
            6'd55: rom_word = 9'h1F4;
            6'd56: rom_word = 9'h1FD;
            6'd57: rom_word = 9'h006;
            6'd58: rom_word = 9'h00F;
            6'd59: rom_word = 9'h018;
            6'd60: rom_word = 9'h021;
            6'd61: rom_word = 9'h02A;
            6'd62: rom_word = 9'h033;
            6'd63: rom_word = 9'h03C;
            default: rom_word = C_Q_RESET;
        endcase
    end

    always_comb begin
        q_d = q_q;
        if (OutClockEn) begin
            q_d = rom_word;
        end
    end

    always_ff @(posedge OutClock or negedge Reset) begin
        if (!Reset) begin
            q_q <= C_Q_RESET;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

`default_nettype wire

// File: tb/tb_romblk_64x9.sv
// ============================================================================
// Module      : tb_romblk_64x9
// Description : Directed vector bench for romblk_64x9.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_romblk_64x9;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [5:0] addr;
    logic [8:0] q;

    int checks;
    int errors;

    typedef struct {
        logic [5:0] addr;
        logic       en;
        logic [8:0] exp_q;
    } vec_t;

    vec_t vecs[10];

    romblk_64x9 #(
        .ADDR_WIDTH(6),
        .DATA_WIDTH(9)
    ) dut (
        .OutClock  (clk),
        .Reset     (rst_n),
        .OutClockEn(en),
        .Address   (addr),
        .Q         (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%03h expected 0x%03h", name, got, exp);
        end
    endtask

    // Drive at the falling edge, then sample just after the next rising edge.
    task automatic apply(input logic [5:0] a, input logic e);
        @(negedge clk);
        addr = a;
        en   = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] model;
        checks = 0;
        errors = 0;

        vecs[0] = '{6'd0,  1'b1, 9'h005};
        vecs[1] = '{6'd1,  1'b1, 9'h00E};
        vecs[2] = '{6'd63, 1'b1, 9'h03C};
        vecs[3] = '{6'd10, 1'b1, 9'h05F};
        vecs[4] = '{6'd2,  1'b0, 9'h05F};
        vecs[5] = '{6'd2,  1'b0, 9'h05F};
        vecs[6] = '{6'd2,  1'b0, 9'h05F};
        vecs[7] = '{6'd2,  1'b1, 9'h017};
        vecs[8] = '{6'd56, 1'b1, 9'h1FD};
        vecs[9] = '{6'd57, 1'b1, 9'h006};

        rst_n = 1'b1;
        en    = 1'b1;
        addr  = 6'd63;
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_async", q, 9'h000);

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", q, 9'h000);
        end

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            apply(vecs[i].addr, vecs[i].en);
            check($sformatf("vec%0d", i), q, vecs[i].exp_q);
        end

        for (int a = 0; a < 64; a++) begin
            model = 9'((9 * a + 5) % 512);
            apply(6'(a), 1'b1);
            check($sformatf("sweep%0d", a), q, model);
        end

        // Address wiggles between edges must not reach Q.
        @(negedge clk);
        addr = 6'd5;
        #1;
        check("addr_no_edge_a", q, 9'h03C);
        addr = 6'd7;
        #1;
        check("addr_no_edge_b", q, 9'h03C);

        // Mid-cycle reset clears without a clock edge.
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_midcycle", q, 9'h000);
        @(posedge clk);
        #1;
        check("reset_midcycle_hold", q, 9'h000);

        @(negedge clk);
        rst_n = 1'b1;
        apply(6'd1, 1'b1);
        check("post_reset_read", q, 9'h00E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
